muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the pipelined MIPS core. It executes the HI/LO-class R-type instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO) that the single-cycle ALU cannot perform. It sits beside the ALU in the execute stage, owns the architectural HI/LO registers, and raises `busy` so the hazard unit stalls the pipeline until a result is ready.

## Interface

Parameters:
- `WIDTH`, 32: operand and HI/LO width. Only 32 is verified.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: execute-stage valid R-type instruction with an HI/LO-class funct. Sampled only when idle.
- `funct`  in  6: instruction funct field.
- `srca`  in  WIDTH: rs value (dividend, multiplicand, or MTHI/MTLO data).
- `srcb`  in  WIDTH: rt value (divisor or multiplier).
- `busy`  out  1: operation in flight; the hazard unit stalls MFHI/MFLO and any new start.
- `done`  out  1: one-cycle pulse in the first cycle HI/LO hold a new mult/div result.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation

Funct decode:
- 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- 010001 MTHI (`hi <= srca`), 010011 MTLO (`lo <= srca`).
- Any other funct with `start`: ignored, no state change.

States:
- IDLE: `busy`=0.
  - start with MULT/MULTU goes to MUL.
  - start with DIV/DIVU and `srcb`≠0 goes to DIV.
  - start with DIV/DIVU and `srcb`=0 goes to FIX.
  - start with MTHI/MTLO writes the register at that edge and stays in IDLE, with no `done` pulse.
- Operand latch (at the edge the start is accepted):
  - Signed ops latch |srca| and |srcb| plus a negate flag per result.
  - Unsigned ops latch operands as-is.
  - The iteration counter loads 31.
- MUL: one radix-2 shift-add step per cycle into a 64-bit accumulator. After the step with counter=0, go to FIX.
- DIV: one restoring shift-subtract step per cycle, producing 32-bit quotient and remainder. After the step with counter=0, go to FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
  - MULT: if the operand signs differ, negate the 64-bit product. `hi` gets the upper half, `lo` the lower half.
  - DIV: quotient negated if the operand signs differ; remainder takes the dividend's sign. `lo` gets the quotient, `hi` the remainder.
  - DIVU/MULTU: no correction.
  - Divide by zero (either signedness): `lo` = 0xFFFFFFFF, `hi` = `srca` as latched (unmodified sign).
  - DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. This falls out of the absolute-value datapath; no special case.
- HI/LO are not modified during MUL/DIV; intermediate values live in internal registers only.
- `start` while `busy`=1 is ignored. This holds even with a legal funct, and MTHI/MTLO are ignored too.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset asserted mid-operation: the next edge forces all reset values and discards the partial result. `start` is accepted at the first edge with `reset`=0.
- `busy` and `done` are registered, decoded from state.
- Mult/div latency, with E0 the edge that accepts the start:
  - Iterations occur at E1..E32.
  - FIX executes at E33.
  - `busy`=1 from after E0 until E33, i.e. 33 cycles.
  - `done`=1 and the new `hi`/`lo` are visible for exactly the cycle after E33, with `busy`=0 in that cycle.
  - A back-to-back start is accepted at E34.
- Divide by zero: E0 goes to FIX and E1 writes the result. `busy` is high for 1 cycle and `done` is high after E1.
- MTHI/MTLO: the register updates at E0. `busy` stays 0 and `done` stays 0.
- `done` and `busy` are never simultaneously 1.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. `busy` is high exactly 33 cycles, `done` pulses once after E33.
- MULT 0xFFFFFFFD (−3) × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV −7 / 2, then DIVU 7 / 2 back-to-back (second start at E34):
  - DIV gives `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU gives `lo`=3, `hi`=1.
  - The second result is done 34 edges after the first.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU 5 / 0 -> `lo`=0xFFFFFFFF, `hi`=5, `busy` high for 1 cycle, `done` after E1.
- Start-while-busy and reset-while-busy:
  - MULT 3 × 4 started; MTLO with `srca`=0x1234 asserted during `busy` is ignored, and the result is `hi`=0, `lo`=12.
  - Then start MULT again and assert `reset` at E10: `busy`=0, `hi`=`lo`=0, no `done`.
  - MTHI 0xABCD at the first post-reset edge gives `hi`=0xABCD.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division.
// Each takes 32 iterations plus one fix-up cycle. MTHI/MTLO write directly when idle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO handled here
// MUL   | one shift-add step per cycle
// DIV   | one shift-subtract step per cycle
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, remaining dividend / quotient bits}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;        // negate product / quotient
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, done_q;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand magnitudes and the single-step datapaths for both algorithms.
    always_comb begin
        op_signed = (funct == F_MULT) || (funct == F_DIV);
        a_mag     = (op_signed && srca[WIDTH-1]) ? -srca : srca;
        b_mag     = (op_signed && srcb[WIDTH-1]) ? -srcb : srcb;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_sh - {1'b0, opnd_q};
        rem_ge    = ~rem_diff[WIDTH];
        prod_fix  = neg_q ? -acc_q : acc_q;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULT, F_MULTU: begin
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            opnd_d    = a_mag;
                            neg_d     = op_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                            rem_neg_d = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = CW'(WIDTH - 1);
                            state_d   = S_MUL;
                        end
                        F_DIV, F_DIVU: begin
                            cnt_d = CW'(WIDTH - 1);
                            if (srcb == '0) begin
                                // Preload the final divide-by-zero result and
                                // let FIX write it through the uncorrected path.
                                acc_d     = {srca, {WIDTH{1'b1}}};
                                neg_d     = 1'b0;
                                rem_neg_d = 1'b0;
                                is_div_d  = 1'b0;
                                state_d   = S_FIX;
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, a_mag};
                                opnd_d    = b_mag;
                                neg_d     = op_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                                rem_neg_d = op_signed && srca[WIDTH-1];
                                is_div_d  = 1'b1;
                                state_d   = S_DIV;
                            end
                        end
                        F_MTHI:  hi_d = srca;
                        F_MTLO:  lo_d = srca;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                acc_d = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], rem_ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_q == S_FIX);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes reference results,
// and the monitor pops and compares them on every done pulse.
module tb_muldiv_seq;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [31:0] hi, lo;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          done_cycs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          busy_run = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always @(posedge clk) cyc++;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl, output int lat);
        longint      sa, sb_v, q, r;
        logic [63:0] p, t;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        lat  = 33;
        rh   = '0;
        rl   = '0;
        case (f)
            F_MULT: begin
                p = sa * sb_v;
                rh = p[63:32];
                rl = p[31:0];
            end
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    rl  = 32'hFFFF_FFFF;
                    rh  = a;
                    lat = 1;
                end else if (f == F_DIV) begin
                    q = sa / sb_v;
                    r = sa % sb_v;
                    t = q;
                    rl = t[31:0];
                    t = r;
                    rh = t[31:0];
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endfunction

    // Monitor: compare on every done pulse and check HI/LO hold while busy.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_busy_excl", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: done=1, expected 0 (nothing pending)");
            end else begin
                e = sb.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("latency", 32'(cyc - e.issue), 32'(e.lat));
                check("busy_cycles", 32'(busy_run), 32'(e.lat));
                done_cycs.push_back(cyc);
            end
        end else if (busy && sb.size() != 0) begin
            check("hold_hi", hi, sb[0].old_hi);
            check("hold_lo", lo, sb[0].old_lo);
        end
        busy_run = busy ? busy_run + 1 : 0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", k);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic bit is_muldiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_not_busy();
        if (is_muldiv(f)) begin
            ref_op(f, a, b, e.hi, e.lo, e.lat);
            e.old_hi = hi_m;
            e.old_lo = lo_m;
            e.issue  = cyc + 1;
            sb.push_back(e);
            hi_m = e.hi;
            lo_m = e.lo;
        end else if (f == F_MTHI) begin
            hi_m = a;
        end else if (f == F_MTLO) begin
            lo_m = a;
        end
        start = 1'b1;
        funct = f;
        srca  = a;
        srcb  = b;
        tick();
        start = 1'b0;
        funct = 6'($urandom);
        srca  = $urandom;
        srcb  = $urandom;
        if (!is_muldiv(f)) begin
            check("direct_hi", hi, hi_m);
            check("direct_lo", lo, lo_m);
            check("direct_busy", 32'(busy), 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 4))
            0:       return $urandom_range(0, 20);
            1:       return 32'hFFFF_FFFF - $urandom_range(0, 20);
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] f;
        reset = 1'b1;
        start = 1'b0;
        funct = '0;
        srca  = '0;
        srcb  = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);

        do_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
        drain();
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);

        do_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        do_op(F_DIVU, 32'd7, 32'd2);
        drain();
        check("divu_hi", hi, 32'd1);
        check("divu_lo", lo, 32'd3);
        if (done_cycs.size() >= 2)
            check("back_to_back_gap", 32'(done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2]), 32'd34);

        do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        check("div_ovf_hi", hi, 32'd0);
        check("div_ovf_lo", lo, 32'h8000_0000);

        do_op(F_DIVU, 32'd5, 32'd0);
        drain();
        check("divz_hi", hi, 32'd5);
        check("divz_lo", lo, 32'hFFFF_FFFF);

        // MTLO while busy must be ignored.
        do_op(F_MULT, 32'd3, 32'd4);
        start = 1'b1;
        funct = F_MTLO;
        srca  = 32'h0000_1234;
        srcb  = 32'd0;
        tick();
        tick();
        start = 1'b0;
        drain();
        check("busy_ignore_hi", hi, 32'd0);
        check("busy_ignore_lo", lo, 32'd12);

        // Reset in the middle of a multiply (asserted for edge E10).
        do_op(F_MULT, 32'd3, 32'd4);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        hi_m = '0;
        lo_m = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        do_op(F_MTHI, 32'h0000_ABCD, 32'd0);
        check("mthi_after_reset", hi, 32'h0000_ABCD);
        repeat (40) tick();

        // Randomized mix of all operations, including undefined functs.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1: f = F_MULT;
                2:    f = F_MULTU;
                3, 4: f = F_DIV;
                5:    f = F_DIVU;
                6:    f = F_MTHI;
                7:    f = F_MTLO;
                8: begin
                    f = 6'($urandom);
                    while (is_muldiv(f) || f == F_MTHI || f == F_MTLO)
                        f = 6'($urandom);
                end
                default: f = ($urandom_range(0, 1) != 0) ? F_DIV : F_DIVU;
            endcase
            if (f == F_DIV || f == F_DIVU)
                do_op(f, rand_opnd(), ($urandom_range(0, 5) == 0) ? 32'd0 : rand_opnd());
            else
                do_op(f, rand_opnd(), rand_opnd());
            if ($urandom_range(0, 3) == 0)
                drain();
        end
        drain();
        check("final_hi", hi, hi_m);
        check("final_lo", lo, lo_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
